// File: rtl/sdram_pkg.sv
// Shared constants, command encodings, FSM states and address helpers for the
// 2M x 32 SDRAM sequencer.
package sdram_pkg;
   localparam int INIT_WAIT        = 17550;
   localparam int REFRESH_INTERVAL = 1368;
   localparam int T_RP             = 2;
   localparam int T_RCD            = 2;
   localparam int T_RFC            = 7;
   localparam int CAS_LATENCY      = 2;
   localparam int N_INIT_REF       = 8;

   localparam int ADDR_W = 21;
   localparam int ROW_W  = 11;
   localparam int COL_W  = 8;
   localparam int BANK_W = 2;
   localparam int CNT_W  = 15;
   localparam int RCNT_W = 11;

   localparam logic [ROW_W-1:0] MRS_MODE = 11'h020;

   // Offsets within an access slot, counted from the ACTIVE cycle.
   localparam int SLOT_CMD    = T_RCD;
   localparam int SLOT_SAMPLE = T_RCD + CAS_LATENCY;
   localparam int SLOT_LEN    = 8;

   typedef enum logic [3:0] {
      CMD_MRS  = 4'b0000,
      CMD_REF  = 4'b0001,
      CMD_PRE  = 4'b0010,
      CMD_ACT  = 4'b0011,
      CMD_WR   = 4'b0100,
      CMD_RD   = 4'b0101,
      CMD_NOP  = 4'b0111,
      CMD_DESL = 4'b1111
   } cmd_e;

   typedef enum logic [2:0] {
      S_INIT_WAIT = 3'd0,
      S_INIT_PRE  = 3'd1,
      S_INIT_REF  = 3'd2,
      S_INIT_MRS  = 3'd3,
      S_IDLE      = 3'd4,
      S_REFRESH   = 3'd5,
      S_ACCESS    = 3'd6
   } state_e;

   function automatic logic [BANK_W-1:0] addr_bank(input logic [ADDR_W-1:0] a);
      return a[20:19];
   endfunction

   function automatic logic [ROW_W-1:0] addr_row(input logic [ADDR_W-1:0] a);
      return a[18:8];
   endfunction

   function automatic logic [COL_W-1:0] addr_col(input logic [ADDR_W-1:0] a);
      return a[7:0];
   endfunction
endpackage

// File: rtl/sdram_sequencer_if.sv
// Requester ports (MSX bus and video) plus SDRAM pins of the sequencer.
interface sdram_sequencer_if;
   logic        init_done;
   logic        cpu_req;
   logic        cpu_wr;
   logic [20:0] cpu_addr;
   logic [31:0] cpu_wdata;
   logic [3:0]  cpu_wmask;
   logic        cpu_ack;
   logic [31:0] cpu_rdata;
   logic        cpu_rvalid;
   logic        vdp_req;
   logic [20:0] vdp_addr;
   logic        vdp_ack;
   logic [31:0] vdp_rdata;
   logic        vdp_rvalid;
   logic        sdram_cke;
   logic        sdram_cs_n;
   logic        sdram_ras_n;
   logic        sdram_cas_n;
   logic        sdram_we_n;
   logic [10:0] sdram_addr;
   logic [1:0]  sdram_ba;
   logic [3:0]  sdram_dqm;
   logic [31:0] sdram_dq_o;
   logic        sdram_dq_oe;
   logic [31:0] sdram_dq_i;

   modport slave (
      input  cpu_req, cpu_wr, cpu_addr, cpu_wdata, cpu_wmask, vdp_req, vdp_addr, sdram_dq_i,
      output init_done, cpu_ack, cpu_rdata, cpu_rvalid, vdp_ack, vdp_rdata, vdp_rvalid,
             sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n,
             sdram_addr, sdram_ba, sdram_dqm, sdram_dq_o, sdram_dq_oe
   );

   modport master (
      output cpu_req, cpu_wr, cpu_addr, cpu_wdata, cpu_wmask, vdp_req, vdp_addr, sdram_dq_i,
      input  init_done, cpu_ack, cpu_rdata, cpu_rvalid, vdp_ack, vdp_rdata, vdp_rvalid,
             sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n,
             sdram_addr, sdram_ba, sdram_dqm, sdram_dq_o, sdram_dq_oe
   );
endinterface

// File: rtl/sdram_refresh_timer.sv
// Free-running auto-refresh interval timer with a sticky pending flag.
module sdram_refresh_timer
   import sdram_pkg::*;
(
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_enable,
   input  logic i_clear,
   output logic o_pending
);
   logic [RCNT_W-1:0] r_count;
   logic              r_pending;

   // Interval counter; a wrap outranks a same-cycle clear so no refresh is lost.
   always_ff @(posedge i_clk) begin
      if (i_reset || !i_enable) begin
         r_count   <= 11'd0;
         r_pending <= 1'b0;
      end else if (r_count == RCNT_W'(REFRESH_INTERVAL - 1)) begin
         r_count   <= 11'd0;
         r_pending <= 1'b1;
      end else begin
         r_count   <= r_count + 11'd1;
         r_pending <= i_clear ? 1'b0 : r_pending;
      end
   end

   assign o_pending = r_pending;
endmodule

// File: rtl/sdram_sequencer.sv
// SDRAM sequencer: power-up init, periodic refresh and single-word
// auto-precharge accesses shared round-robin between the cpu and vdp ports.
module sdram_sequencer
   import sdram_pkg::*;
(
   input logic              i_clk,
   input logic              i_reset,
   sdram_sequencer_if.slave io_bus
);
   state_e            r_state;
   logic [CNT_W-1:0]  r_cnt;
   logic [2:0]        r_ref_cnt;
   logic              r_last_vdp;
   logic              r_is_vdp;
   logic              r_is_wr;
   logic [ADDR_W-1:0] r_req_addr;
   logic [31:0]       r_wdata;
   logic [3:0]        r_wmask;
   cmd_e              r_cmd;
   logic              r_cke;
   logic [ROW_W-1:0]  r_sd_addr;
   logic [BANK_W-1:0] r_ba;
   logic [3:0]        r_dqm;
   logic [31:0]       r_dq_o;
   logic              r_dq_oe;
   logic              r_init_done;
   logic              r_cpu_ack;
   logic              r_vdp_ack;
   logic              r_cpu_rvalid;
   logic              r_vdp_rvalid;
   logic [31:0]       r_cpu_rdata;
   logic [31:0]       r_vdp_rdata;

   logic              w_ref_pending;
   logic              w_ref_clear;
   logic              w_cpu_win;
   logic              w_vdp_win;
   logic [ADDR_W-1:0] w_sel_addr;

   sdram_refresh_timer u_refresh (
      .i_clk     (i_clk),
      .i_reset   (i_reset),
      .i_enable  (r_init_done),
      .i_clear   (w_ref_clear),
      .o_pending (w_ref_pending)
   );

   // Arbitration: refresh first, then the port that was not granted last.
   always_comb begin
      w_cpu_win  = 1'b0;
      w_vdp_win  = 1'b0;
      w_sel_addr = io_bus.cpu_addr;
      if (r_state == S_IDLE && !w_ref_pending) begin
         if (io_bus.cpu_req && (!io_bus.vdp_req || r_last_vdp)) begin
            w_cpu_win = 1'b1;
         end else if (io_bus.vdp_req) begin
            w_vdp_win  = 1'b1;
            w_sel_addr = io_bus.vdp_addr;
         end else begin
            w_cpu_win = 1'b0;
         end
      end else begin
         w_vdp_win = 1'b0;
      end
   end

   assign w_ref_clear = (r_state == S_IDLE) && w_ref_pending;

   // Sequencer FSM; r_cnt is the offset of the cycle currently on the pins.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state      <= S_INIT_WAIT;
         r_cnt        <= 15'd0;
         r_ref_cnt    <= 3'd0;
         r_last_vdp   <= 1'b1;
         r_is_vdp     <= 1'b0;
         r_is_wr      <= 1'b0;
         r_req_addr   <= 21'd0;
         r_wdata      <= 32'd0;
         r_wmask      <= 4'd0;
         r_cmd        <= CMD_DESL;
         r_cke        <= 1'b0;
         r_sd_addr    <= 11'd0;
         r_ba         <= 2'd0;
         r_dqm        <= 4'hF;
         r_dq_o       <= 32'd0;
         r_dq_oe      <= 1'b0;
         r_init_done  <= 1'b0;
         r_cpu_ack    <= 1'b0;
         r_vdp_ack    <= 1'b0;
         r_cpu_rvalid <= 1'b0;
         r_vdp_rvalid <= 1'b0;
         r_cpu_rdata  <= 32'd0;
         r_vdp_rdata  <= 32'd0;
      end else begin
         r_cke        <= 1'b1;
         r_cmd        <= CMD_NOP;
         r_dqm        <= 4'hF;
         r_dq_oe      <= 1'b0;
         r_cpu_ack    <= 1'b0;
         r_vdp_ack    <= 1'b0;
         r_cpu_rvalid <= 1'b0;
         r_vdp_rvalid <= 1'b0;
         r_cnt        <= r_cnt + 15'd1;
         case (r_state)
            S_INIT_WAIT: begin
               if (r_cnt == CNT_W'(INIT_WAIT)) begin
                  r_cmd     <= CMD_PRE;
                  r_sd_addr <= 11'h400;
                  r_state   <= S_INIT_PRE;
                  r_cnt     <= 15'd0;
               end
            end
            S_INIT_PRE: begin
               if (r_cnt == CNT_W'(T_RP - 1)) begin
                  r_cmd     <= CMD_REF;
                  r_ref_cnt <= 3'd0;
                  r_state   <= S_INIT_REF;
                  r_cnt     <= 15'd0;
               end
            end
            S_INIT_REF: begin
               if (r_cnt == CNT_W'(T_RFC - 1)) begin
                  r_cnt <= 15'd0;
                  if (r_ref_cnt == 3'(N_INIT_REF - 1)) begin
                     r_cmd     <= CMD_MRS;
                     r_sd_addr <= MRS_MODE;
                     r_ba      <= 2'd0;
                     r_state   <= S_INIT_MRS;
                  end else begin
                     r_cmd     <= CMD_REF;
                     r_ref_cnt <= r_ref_cnt + 3'd1;
                  end
               end
            end
            S_INIT_MRS: begin
               if (r_cnt == 15'd1) begin
                  r_state     <= S_IDLE;
                  r_init_done <= 1'b1;
               end
            end
            S_IDLE: begin
               if (w_ref_pending) begin
                  r_cmd   <= CMD_REF;
                  r_state <= S_REFRESH;
                  r_cnt   <= 15'd0;
               end else if (w_cpu_win || w_vdp_win) begin
                  r_cmd      <= CMD_ACT;
                  r_ba       <= addr_bank(w_sel_addr);
                  r_sd_addr  <= addr_row(w_sel_addr);
                  r_req_addr <= w_sel_addr;
                  r_is_vdp   <= w_vdp_win;
                  r_is_wr    <= w_cpu_win && io_bus.cpu_wr;
                  r_wdata    <= io_bus.cpu_wdata;
                  r_wmask    <= io_bus.cpu_wmask;
                  r_cpu_ack  <= w_cpu_win;
                  r_vdp_ack  <= w_vdp_win;
                  r_last_vdp <= w_vdp_win;
                  r_state    <= S_ACCESS;
                  r_cnt      <= 15'd0;
               end
            end
            S_REFRESH: begin
               if (r_cnt == CNT_W'(T_RFC - 2)) begin
                  r_state <= S_IDLE;
               end
            end
            S_ACCESS: begin
               if (r_cnt == CNT_W'(SLOT_CMD - 1)) begin
                  r_cmd     <= r_is_wr ? CMD_WR : CMD_RD;
                  r_sd_addr <= {3'b100, addr_col(r_req_addr)};
                  r_dqm     <= r_is_wr ? ~r_wmask : 4'h0;
                  r_dq_oe   <= r_is_wr;
                  r_dq_o    <= r_wdata;
               end
               if (r_cnt == CNT_W'(SLOT_SAMPLE) && !r_is_wr) begin
                  if (r_is_vdp) begin
                     r_vdp_rdata  <= io_bus.sdram_dq_i;
                     r_vdp_rvalid <= 1'b1;
                  end else begin
                     r_cpu_rdata  <= io_bus.sdram_dq_i;
                     r_cpu_rvalid <= 1'b1;
                  end
               end
               if (r_cnt == CNT_W'(SLOT_LEN - 2)) begin
                  r_state <= S_IDLE;
               end
            end
            default: begin
               r_state <= S_INIT_WAIT;
               r_cnt   <= 15'd0;
            end
         endcase
      end
   end

   assign io_bus.init_done   = r_init_done;
   assign io_bus.cpu_ack     = r_cpu_ack;
   assign io_bus.cpu_rdata   = r_cpu_rdata;
   assign io_bus.cpu_rvalid  = r_cpu_rvalid;
   assign io_bus.vdp_ack     = r_vdp_ack;
   assign io_bus.vdp_rdata   = r_vdp_rdata;
   assign io_bus.vdp_rvalid  = r_vdp_rvalid;
   assign io_bus.sdram_cke   = r_cke;
   assign {io_bus.sdram_cs_n, io_bus.sdram_ras_n, io_bus.sdram_cas_n, io_bus.sdram_we_n} = r_cmd;
   assign io_bus.sdram_addr  = r_sd_addr;
   assign io_bus.sdram_ba    = r_ba;
   assign io_bus.sdram_dqm   = r_dqm;
   assign io_bus.sdram_dq_o  = r_dq_o;
   assign io_bus.sdram_dq_oe = r_dq_oe;
endmodule

// File: tb/tb_sdram_sequencer.sv
// Directed self-checking bench for sdram_sequencer with a small behavioural
// SDRAM model (open row per bank, CL2, byte masks).
`timescale 1ns/1ps
module tb_sdram_sequencer;
   localparam int        EXP_INIT_WAIT = 17550;
   localparam logic [3:0] C_NOP = 4'b0111, C_ACT = 4'b0011, C_RD  = 4'b0101, C_WR = 4'b0100,
                          C_PRE = 4'b0010, C_REF = 4'b0001, C_MRS = 4'b0000, C_DESL = 4'b1111;
   localparam logic [20:0] ADDR_A = 21'h0A_1234;
   localparam logic [20:0] ADDR_B = 21'h1F_0ABC;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_errors = 0;

   sdram_sequencer_if bus ();

   sdram_sequencer dut (
      .i_clk   (clk),
      .i_reset (reset),
      .io_bus  (bus)
   );

   always #5.698 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [3:0] cmd_now();
      return {bus.sdram_cs_n, bus.sdram_ras_n, bus.sdram_cas_n, bus.sdram_we_n};
   endfunction

   // Behavioural SDRAM: commands taken at the rising edge, read data CL2 later.
   logic [31:0] mem [logic [20:0]];
   logic [10:0] open_row [4];
   logic        rd_pend_v = 1'b0;
   logic [20:0] rd_pend_a = 21'd0;

   function automatic logic [31:0] mem_rd(input logic [20:0] a);
      return mem.exists(a) ? mem[a] : 32'h0;
   endfunction

   always @(posedge clk) begin
      logic [20:0] a;
      logic [31:0] w;
      a = {bus.sdram_ba, open_row[bus.sdram_ba], bus.sdram_addr[7:0]};
      if (bus.sdram_cke && cmd_now() == C_ACT) open_row[bus.sdram_ba] = bus.sdram_addr;
      if (bus.sdram_cke && cmd_now() == C_WR && bus.sdram_dq_oe) begin
         w = mem_rd(a);
         for (int l = 0; l < 4; l++)
            if (!bus.sdram_dqm[l]) w[l*8 +: 8] = bus.sdram_dq_o[l*8 +: 8];
         mem[a] = w;
      end
      rd_pend_v      <= bus.sdram_cke && cmd_now() == C_RD && bus.sdram_dqm == 4'h0;
      rd_pend_a      <= a;
      bus.sdram_dq_i <= rd_pend_v ? mem_rd(rd_pend_a) : 32'h0;
   end

   // Refresh spacing and refresh/ACT overlap observer.
   int last_ref = -1, n_ref_seen = 0, min_gap = 1 << 30, max_gap = 0, overlap = 0;
   always @(negedge clk) begin
      if (!bus.init_done) begin
         last_ref = -1;
      end else begin
         if (cmd_now() == C_ACT && last_ref >= 0 && (cyc - last_ref) < 7) overlap++;
         if (cmd_now() == C_REF) begin
            if (last_ref >= 0) begin
               if (cyc - last_ref < min_gap) min_gap = cyc - last_ref;
               if (cyc - last_ref > max_gap) max_gap = cyc - last_ref;
            end
            last_ref = cyc;
            n_ref_seen++;
         end
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, "_cke"},   32'(bus.sdram_cke), 32'd0);
      check_eq({tag, "_cmd"},   32'(cmd_now()), 32'(C_DESL));
      check_eq({tag, "_addr"},  32'({bus.sdram_ba, bus.sdram_addr}), 32'd0);
      check_eq({tag, "_dqm"},   32'(bus.sdram_dqm), 32'hF);
      check_eq({tag, "_dq"},    32'({bus.sdram_dq_oe, bus.sdram_dq_o != 32'd0}), 32'd0);
      check_eq({tag, "_idone"}, 32'(bus.init_done), 32'd0);
      check_eq({tag, "_pulse"}, 32'({bus.cpu_ack, bus.vdp_ack, bus.cpu_rvalid, bus.vdp_rvalid}), 32'd0);
      check_eq({tag, "_rdata"}, bus.cpu_rdata | bus.vdp_rdata, 32'd0);
   endtask

   // Call right after reset is released at a falling edge.
   task automatic run_init_check(input string tag);
      int n_nop, n_ref, k, m;
      n_nop = 0;
      @(negedge clk);
      while (cmd_now() == C_NOP && bus.sdram_cke && n_nop < EXP_INIT_WAIT + 16) begin
         n_nop++;
         @(negedge clk);
      end
      check_eq({tag, "_nop_count"}, n_nop, EXP_INIT_WAIT);
      check_eq({tag, "_pre"}, 32'({cmd_now(), bus.sdram_addr[10]}), 32'({C_PRE, 1'b1}));
      n_ref = 0;
      k = 0;
      while (cmd_now() != C_MRS && k < 200) begin
         @(negedge clk);
         k++;
         if (cmd_now() == C_REF) n_ref++;
      end
      check_eq({tag, "_ref_count"}, n_ref, 8);
      check_eq({tag, "_pre_to_mrs"}, k, 58);
      check_eq({tag, "_mrs_mode"}, 32'(bus.sdram_addr), 32'h020);
      m = 0;
      while (!bus.init_done && m < 10) begin
         @(negedge clk);
         m++;
      end
      check_eq({tag, "_init_done_lat"}, m, 2);
   endtask

   // One access on the chosen port; called at a falling edge.
   task automatic do_access(input logic vdp, input logic wr, input logic [20:0] a,
                            input logic [31:0] wd, input logic [3:0] wm,
                            output logic acked, output int lat, output logic [31:0] rd);
      if (vdp) begin
         bus.vdp_req  = 1'b1;
         bus.vdp_addr = a;
      end else begin
         bus.cpu_req   = 1'b1;
         bus.cpu_wr    = wr;
         bus.cpu_addr  = a;
         bus.cpu_wdata = wd;
         bus.cpu_wmask = wm;
      end
      acked = 1'b0;
      for (int i = 0; i < 2000 && !acked; i++) begin
         @(negedge clk);
         acked = vdp ? bus.vdp_ack : bus.cpu_ack;
      end
      bus.cpu_req = 1'b0;
      bus.vdp_req = 1'b0;
      lat = -1;
      rd  = 32'd0;
      for (int i = 1; i <= 10; i++) begin
         @(negedge clk);
         if ((vdp ? bus.vdp_rvalid : bus.cpu_rvalid) && lat < 0) begin
            lat = i;
            rd  = vdp ? bus.vdp_rdata : bus.cpu_rdata;
         end
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic        acked;
      int          lat, n, dbl, acks, rvs, bad;
      logic [31:0] rd;
      int          who [6];
      int          at  [6];
      logic        seen_rv;

      bus.cpu_req = 1'b0; bus.cpu_wr = 1'b0; bus.cpu_addr = 21'd0;
      bus.cpu_wdata = 32'd0; bus.cpu_wmask = 4'd0;
      bus.vdp_req = 1'b0; bus.vdp_addr = 21'd0;
      repeat (5) @(negedge clk);
      check_reset_outputs("rst0");

      reset = 1'b0;
      run_init_check("init1");

      do_access(1'b0, 1'b1, ADDR_A, 32'hDEADBEEF, 4'hF, acked, lat, rd);
      check_eq("wr_a_ack", 32'(acked), 32'd1);
      check_eq("wr_a_no_rvalid", lat, -1);
      do_access(1'b0, 1'b0, ADDR_A, 32'd0, 4'h0, acked, lat, rd);
      check_eq("rd_a_ack", 32'(acked), 32'd1);
      check_eq("rd_a_latency", lat, 5);
      check_eq("rd_a_data", rd, 32'hDEADBEEF);

      do_access(1'b0, 1'b1, ADDR_B, 32'hAABBCCDD, 4'hF, acked, lat, rd);
      do_access(1'b0, 1'b1, ADDR_B, 32'h11223344, 4'b0101, acked, lat, rd);
      do_access(1'b0, 1'b0, ADDR_B, 32'd0, 4'h0, acked, lat, rd);
      check_eq("rd_b_masked", rd, 32'hAA22CC44);

      do_access(1'b1, 1'b0, ADDR_A, 32'd0, 4'h0, acked, lat, rd);
      check_eq("vdp_rd_ack", 32'(acked), 32'd1);
      check_eq("vdp_rd_latency", lat, 5);
      check_eq("vdp_rd_data", rd, 32'hDEADBEEF);

      // Both ports held together: grants alternate starting with cpu.
      bus.cpu_req = 1'b1; bus.cpu_wr = 1'b0; bus.cpu_addr = ADDR_A;
      bus.vdp_req = 1'b1; bus.vdp_addr = ADDR_B;
      n = 0;
      dbl = 0;
      for (int i = 0; i < 200 && n < 6; i++) begin
         @(negedge clk);
         if (bus.cpu_ack && bus.vdp_ack) dbl++;
         if (bus.cpu_ack) begin
            who[n] = 0; at[n] = cyc; n++;
         end else if (bus.vdp_ack) begin
            who[n] = 1; at[n] = cyc; n++;
         end
      end
      bus.cpu_req = 1'b0;
      bus.vdp_req = 1'b0;
      check_eq("rr_ack_count", n, 6);
      check_eq("rr_double_ack", dbl, 0);
      for (int k = 0; k < n; k++) check_eq("rr_order", who[k], k % 2);
      for (int k = 1; k < n; k++) check_eq("rr_slot_gap", at[k] - at[k-1], 8);
      repeat (10) @(negedge clk);

      // Continuous video reads across refresh intervals.
      bus.vdp_req  = 1'b1;
      bus.vdp_addr = ADDR_B;
      acks = 0; rvs = 0; bad = 0;
      for (int i = 0; i < 3010; i++) begin
         @(negedge clk);
         if (i == 3000) bus.vdp_req = 1'b0;
         if (bus.vdp_ack) acks++;
         if (bus.vdp_rvalid) begin
            rvs++;
            if (bus.vdp_rdata !== 32'hAA22CC44) bad++;
         end
      end
      #1;
      check_eq("stream_ack_rate", 32'(acks >= 360 && acks <= 376), 32'd1);
      check_eq("stream_rvalid_count", rvs, acks);
      check_eq("stream_data", bad, 0);
      check_eq("refresh_seen", 32'(n_ref_seen >= 2), 32'd1);
      check_eq("refresh_min_gap", 32'(min_gap >= 1360), 32'd1);
      check_eq("refresh_max_gap", 32'(max_gap <= 1376), 32'd1);
      check_eq("refresh_overlap", overlap, 0);

      // Reset three cycles into a read drops it and restarts init.
      bus.cpu_req = 1'b1; bus.cpu_wr = 1'b0; bus.cpu_addr = ADDR_A;
      acked = 1'b0;
      for (int i = 0; i < 2000 && !acked; i++) begin
         @(negedge clk);
         acked = bus.cpu_ack;
      end
      bus.cpu_req = 1'b0;
      check_eq("rst_rd_ack", 32'(acked), 32'd1);
      repeat (3) @(negedge clk);
      reset = 1'b1;
      seen_rv = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (bus.cpu_rvalid) seen_rv = 1'b1;
      end
      check_eq("rst_no_rvalid", 32'(seen_rv), 32'd0);
      check_reset_outputs("rst1");
      reset = 1'b0;
      run_init_check("init2");
      do_access(1'b0, 1'b0, ADDR_A, 32'd0, 4'h0, acked, lat, rd);
      check_eq("post_rst_rd_latency", lat, 5);
      check_eq("post_rst_rd_data", rd, 32'hDEADBEEF);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
